// File: rtl/byte_bank_serializer_8.sv
// Snapshot-and-stream serializer: captures an 8-lane byte bank in one cycle and emits
// it lane 0 first over a valid/ready handshake. Optional: SERIALIZER_BACK_TO_BACK_EN.
module byte_bank_serializer_8 #(
  parameter int DATA_WIDTH = 8,
  parameter int BANK_DEPTH = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load,
  input  logic [BANK_DEPTH*DATA_WIDTH-1:0] bank_in,
  output logic                             load_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [SEL_WIDTH-1:0]             out_index,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy
);

  localparam logic [SEL_WIDTH-1:0] LAST_INDEX = SEL_WIDTH'(BANK_DEPTH - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [SEL_WIDTH-1:0]  r_index;
  logic [SEL_WIDTH-1:0]  w_index_next;
  logic [DATA_WIDTH-1:0] r_shadow [BANK_DEPTH];
  logic [DATA_WIDTH-1:0] w_lane   [BANK_DEPTH];
  logic                  w_last;
  logic                  w_beat;
  logic                  w_load_accept;

  generate
    for (genvar gi = 0; gi < BANK_DEPTH; gi++) begin : g_lane
      assign w_lane[gi] = bank_in[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  assign w_last = (r_state == S_STREAM) && (r_index == LAST_INDEX);
  assign w_beat = (r_state == S_STREAM) && out_ready;

`ifdef SERIALIZER_BACK_TO_BACK_EN
  // A new bank may replace the old one only on the edge that retires its last lane.
  assign w_load_accept = load && ((r_state == S_IDLE) || (w_last && out_ready));
`else
  assign w_load_accept = load && (r_state == S_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_index <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < BANK_DEPTH; k++) begin
        r_shadow[k] <= '0;
      end
    end else if (w_load_accept) begin
      for (int k = 0; k < BANK_DEPTH; k++) begin
        r_shadow[k] <= w_lane[k];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    case (r_state)
      S_IDLE: begin
        if (w_load_accept) begin
          w_state_next = S_STREAM;
          w_index_next = '0;
        end
      end
      S_STREAM: begin
        if (w_beat) begin
          if (w_last) begin
            w_index_next = '0;
            w_state_next = w_load_accept ? S_STREAM : S_IDLE;
          end else begin
            w_index_next = r_index + SEL_WIDTH'(1);
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_index_next = '0;
      end
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    out_index  = '0;
    case (r_state)
      S_IDLE: begin
        load_ready = 1'b1;
      end
      S_STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = w_last;
        out_data  = r_shadow[r_index];
        out_index = r_index;
`ifdef SERIALIZER_BACK_TO_BACK_EN
        load_ready = w_last;
`endif
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_byte_bank_serializer_8.sv
// Bench for byte_bank_serializer_8: directed test-plan steps then random traffic,
// checked against a queue-of-pending-beats reference model.
module tb_byte_bank_serializer_8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [63:0] bank_in = '0;
  logic        load_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_index;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;

`ifdef SERIALIZER_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  byte_bank_serializer_8 dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .bank_in    (bank_in),
    .load_ready (load_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] idx;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] delivered[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic tick(input logic ld, input logic [63:0] bk, input logic rdy);
    logic exp_valid, exp_lr, accept, xfer;
    load = ld;
    bank_in = bk;
    out_ready = rdy;
    exp_valid = (exp_q.size() > 0);
    exp_lr = (exp_q.size() == 0) || (B2B && exp_q.size() == 1);
    accept = ld && ((exp_q.size() == 0) || (B2B && exp_q.size() == 1 && rdy));
    xfer = exp_valid && rdy;
    chk("out_valid", out_valid, exp_valid);
    chk("busy", busy, exp_valid);
    chk("load_ready", load_ready, exp_lr);
    if (exp_valid) begin
      chk("out_data", out_data, exp_q[0].data);
      chk("out_index", out_index, exp_q[0].idx);
      chk("out_last", out_last, exp_q[0].idx == 3'd7);
    end else begin
      chk("out_last_idle", out_last, 1'b0);
    end
    if (xfer) delivered.push_back(out_data);
    @(posedge clk);
    #1;
    if (xfer) void'(exp_q.pop_front());
    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        beat_t b;
        b.data = bk[8*k +: 8];
        b.idx  = 3'(k);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    load = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    exp_q.delete();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_index", out_index, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_load_ready", load_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] held;
    // Reset and basic stream
    do_reset(2);
    tick(1'b1, 64'h0706050403020100, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b0, 64'h0, 1'b1);
    tick(1'b0, 64'h0, 1'b1);
    $display("basic stream done, checks=%0d", n_checks);

    // Backpressure with a fixed ready pattern
    delivered.delete();
    tick(1'b1, 64'h8877665544332211, 1'b0);
    held = out_data;
    begin
      logic [10:0] pat;
      pat = 11'b11111101001; // applied LSB first: 1,0,0,1,0,1,1,1,1,1,1
      for (int i = 0; i < 11; i++) begin
        if (i > 0 && !pat[i-1]) chk("bp_stable", out_data, held);
        held = out_data;
        tick(1'b0, 64'h0, pat[i]);
      end
    end
    tick(1'b0, 64'h0, 1'b1);
    chk("bp_count", 64'(delivered.size()), 64'd8);
    for (int k = 0; k < 8 && k < delivered.size(); k++)
      chk("bp_byte", delivered[k], 8'(8'h11 * (k + 1)));
    $display("backpressure done, checks=%0d", n_checks);

    // Load attempt in the middle of a stream is ignored
    tick(1'b1, 64'h0706050403020100, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 64'h0, 1'b1);
    chk("mid_load_ready", load_ready, 1'b0);
    tick(1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    tick(1'b0, 64'h0, 1'b1);
    $display("load during stream done, checks=%0d", n_checks);

    // Reset while lane 4 is on the bus
    tick(1'b1, 64'h2827262524232221, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 64'h0, 1'b1);
    chk("pre_rst_index", out_index, 3'd4);
    do_reset(1);
    tick(1'b1, 64'h3837363534333231, 1'b1);
    for (int i = 0; i < 9; i++) tick(1'b0, 64'h0, 1'b1);
    $display("reset mid-stream done, checks=%0d", n_checks);

    // Back-to-back: bank B requested on the lane-7 beat, load held until accepted
    tick(1'b1, 64'h0706050403020100, 1'b1);
    for (int i = 0; i < 7; i++) tick(1'b0, 64'h0, 1'b1);
    chk("b2b_last", out_last, 1'b1);
    tick(1'b1, 64'h1716151413121110, 1'b1);
    chk("b2b_gap", out_valid, B2B);
    if (!B2B) tick(1'b1, 64'h1716151413121110, 1'b1);
    for (int i = 0; i < 9; i++) tick(1'b0, 64'h0, 1'b1);
    $display("back-to-back done, checks=%0d", n_checks);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 2) == 0), {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
    end
    $display("random traffic done, checks=%0d", n_checks);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_bank_serializer_8.md
Name: byte_bank_serializer_8

Overview:
- Read-side counterpart of the 8-byte register bank.
- Captures a full 8 x 8-bit bank snapshot in one cycle, then streams it out one byte per handshake, lowest index first.
- Intended to feed one row or column of the systolic array from a bank filled by the byte-wise writer.
- Reports the byte index on each beat, so the downstream block knows the position in the bank.

Parameters:
- DATA_WIDTH, 8, width of one byte lane
- BANK_DEPTH, 8, number of lanes in the bank
- SEL_WIDTH, 3, index width; must satisfy 2**SEL_WIDTH == BANK_DEPTH

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  request to capture bank_in
- bank_in  input  BANK_DEPTH*DATA_WIDTH  parallel bank; lane k occupies bits [DATA_WIDTH*k +: DATA_WIDTH]
- load_ready  output  1  block can accept load this cycle
- out_data  output  DATA_WIDTH  current byte
- out_index  output  SEL_WIDTH  lane index of out_data
- out_valid  output  1  out_data and out_index are valid
- out_ready  input  1  downstream accepts the current beat
- out_last  output  1  current beat is lane BANK_DEPTH-1
- busy  output  1  high while in STREAM

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset (clk edge with reset=1):
  - state becomes IDLE
  - shadow bank is cleared to 0 and index to 0
  - out_valid=0, out_last=0, busy=0, out_data=0, out_index=0
  - load_ready=1 from the first cycle after reset
- Reset has priority over all other inputs, including mid-stream; a partially sent bank is discarded.
- FSM states: IDLE and STREAM.
- IDLE:
  - load_ready=1, out_valid=0
  - on load=1, bank_in is copied to the shadow bank, index is set to 0, and the next state is STREAM
- STREAM:
  - load_ready=0 and load is ignored; the shadow bank is not modified
  - out_valid=1, busy=1
  - out_data = shadow[index], out_index = index
  - out_last = (index == BANK_DEPTH-1)
- Beat transfer occurs on a clk edge where out_valid && out_ready:
  - if index < BANK_DEPTH-1: index increments by 1
  - if index == BANK_DEPTH-1: index wraps to 0 and the next state is IDLE
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable. There is no timeout.
- out_ready is don't-care when out_valid=0.
- Latency:
  - load accepted at edge N gives out_valid=1 with lane 0 in the cycle after edge N
  - with out_ready held at 1, lanes 0..7 appear on 8 consecutive cycles
  - IDLE is re-entered after the edge that transfers lane 7, so load-to-next-load is 9 cycles
- A change on bank_in after capture has no effect on the stream in progress.
- All outputs are derived from registered state only, with no combinational path from load or bank_in. out_ready affects state only at the edge.

Optional Feature:
- Macro: SERIALIZER_BACK_TO_BACK_EN
- Defined:
  - load_ready is also asserted in STREAM during the beat where out_last=1, and that beat's out_ready=1 is required for a load to be accepted.
  - If load=1 and the last beat transfers on the same edge, bank_in is captured, index is set to 0 and the state stays STREAM. Lane 0 of the new bank follows lane 7 with no gap, giving 8-cycle load-to-load.
  - If load=1 but out_ready=0 on the last beat, the load is not accepted.
- Not defined: the behaviour is exactly as above, with load_ready=0 throughout STREAM.

Test Plan:
- Basic stream:
  - Stimulus: reset 2 cycles; bank_in=64'h0706050403020100; load pulse for 1 cycle; out_ready=1.
  - Required: bytes 00,01,...,07 on 8 consecutive cycles with out_index 0..7; out_last only with byte 07; out_valid=0 and load_ready=1 on the following cycle.
- Backpressure:
  - Stimulus: bank_in=64'h8877665544332211; out_ready pattern 1,0,0,1,0,1,1,1,1,1,1.
  - Required: every byte 11..88 delivered exactly once, in order; out_data is stable while out_ready=0.
- Load during stream:
  - Stimulus: while streaming 64'h0706050403020100, assert load with bank_in=64'hFFFFFFFFFFFFFFFF at beat 3.
  - Required: load_ready=0 and the stream continues 03..07 unchanged.
- Reset mid-stream:
  - Stimulus: assert reset during the beat with out_index=4.
  - Required: next cycle out_valid=0, out_data=0, out_index=0, busy=0, load_ready=1. A new load then streams from lane 0.
- Back-to-back (macro defined):
  - Stimulus: load bank A=64'h0706050403020100; assert load with bank B=64'h1716151413121110 on the lane-7 beat.
  - Required: bytes 00..07 then 10..17 on 16 consecutive cycles.
  - Without the macro, the same stimulus requires one idle cycle and load held until load_ready=1.
